datamem_responder: RTL and testbench
====================================

# datamem_responder

Data-memory responder for the pipelined CPU. Accepts one load/store request at a time from the memory stage and services it after a fixed, parameterised latency. Returns little-endian, zero-extended load data or commits store bytes. Drives a stall to the pipeline while busy and flags illegal accesses instead of performing them.

## Interface

Parameters:
- `DEPTH_BYTES`, 1024: byte capacity; power of two, ≥ 8.
- `LATENCY`, 2: cycles from request accept to response; ≥ 1.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present this cycle.
- `req_ready` out 1: responder can accept a request this cycle.
- `req_write` in 1: 1 means store, 0 means load.
- `req_addr` in 64: byte address.
- `req_wdata` in 64: store data; low `req_size` bytes are used.
- `req_size` in 4: transfer byte count; legal values are 1, 2, 4, 8.
- `resp_valid` out 1: one-cycle response strobe.
- `resp_rdata` out 64: load data, zero-extended; 0 for stores and errors.
- `resp_err` out 1: qualified by `resp_valid`; illegal access.
- `stall` out 1: `req_valid & ~req_ready`, purely combinational.

## Operation

States:
- `IDLE`: `req_ready`=1.
- `BUSY`: `req_ready`=0; latency counter running.
- `RESP`: `resp_valid`=1 and `req_ready`=1.

Transitions:
- A request is accepted when `req_valid & req_ready`.
- On accept, the block latches write/addr/wdata/size and loads the counter with `LATENCY-1`.
- If `LATENCY`=1, accept goes directly to `RESP`; otherwise it goes to `BUSY`.
- `BUSY` decrements the counter each cycle and moves to `RESP` on the edge where the counter is 1.
- `RESP` goes to `IDLE`, or back to `BUSY`/`RESP` if a new request is accepted in the same cycle. Back-to-back accepts are legal.

Legality checks, evaluated on latched fields:
- `size ∈ {1,2,4,8}`.
- `addr % size == 0`.
- `addr + size ≤ DEPTH_BYTES`, computed without 64-bit overflow: any upper address bit above log2(DEPTH_BYTES) set means illegal.
- If any check fails, the response carries `resp_err`=1, `resp_rdata`=0, and memory is not modified.

Store behaviour:
- Bytes `wdata[8k+7:8k]` are written to `mem[addr+k]` for k < size.
- The commit happens on the edge that enters `RESP`.

Load behaviour:
- `rdata[8k+7:8k] = mem[addr+k]` for k < size; upper bytes are 0.
- The value is sampled on the edge entering `RESP` and held on the outputs during `RESP`.

Memory contents:
- Not reset; contents are undefined until written.
- Loads of never-written bytes are unchecked.

## Timing

- Request accepted at edge N means `resp_valid` is high during cycle N+`LATENCY`, exactly one cycle.
- A store is visible to a load accepted in or after its `RESP` cycle.
- Throughput is one request per `LATENCY` cycles.
- Request fields must be held stable only in the accept cycle.
- Reset values:
  - state=`IDLE`, so `req_ready`=1;
  - `resp_valid`=0, `resp_rdata`=0, `resp_err`=0;
  - counter=0.
- Reset asserted mid-request: the in-flight request is discarded, a pending store is not committed, and no response is produced.
- `resp_rdata` and `resp_err` return to 0 outside `RESP`.

## Structure

- The shared package `mem_pkg` holds:
  - a state enum (`IDLE`, `BUSY`, `RESP`);
  - size constants `XFER_B`=1, `XFER_H`=2, `XFER_W`=4, `XFER_D`=8;
  - a request struct (write, addr, wdata, size).
- The CPU control path uses the same size constants.
- One sub-module, `byte_ram`: a byte-addressed array with an 8-lane write-enable and an 8-byte read port, indexed by base address.
  - Lane k maps to address base+k.
  - The FSM, legality checks and counter stay in `datamem_responder`.

## Test plan

- **Reset and idle:** hold `reset`=0 for 2 cycles, then release. Expect `req_ready`=1, `resp_valid`=0, `stall`=0.
- **Doubleword round trip (`LATENCY`=2):**
  - Store `addr`=0x10, size 8, `wdata`=0x1122334455667788 at cycle 0. Expect `resp_valid` at cycle 2 with `err`=0 and `rdata`=0.
  - Then load 0x10, size 8. Expect `rdata`=0x1122334455667788 at accept+2.
- **Byte access:**
  - Store 0xAB to `addr` 0x13, size 1, then load 0x10, size 8. Expect 0x11223344AB667788.
  - Load 0x13, size 1. Expect `rdata`=0x00000000000000AB.
- **Errors:**
  - Load 0x12, size 4 (misaligned): `err`=1, `rdata`=0.
  - Store to `DEPTH_BYTES`-4, size 8: `err`=1, and a following legal load of `DEPTH_BYTES`-8 shows unchanged data.
  - Size 3: `err`=1.
- **Back-to-back and stall:**
  - Hold `req_valid`=1 for 3 requests with `LATENCY`=3. Expect `stall`=1 in the two `BUSY` cycles of each request.
  - Expect accepts at cycles 0, 3, 6 and responses at cycles 3, 6, 9.
- **Reset mid-store:** accept a store to 0x20, assert `reset` in the `BUSY` cycle, then release. Expect no `resp_valid`, and a later load of 0x20 does not return the store data.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and transfer-size constants for the data-memory path.
// The CPU control path uses the same XFER_* encodings for its size field.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [3:0] XFER_B = 4'd1;
  localparam logic [3:0] XFER_H = 4'd2;
  localparam logic [3:0] XFER_W = 4'd4;
  localparam logic [3:0] XFER_D = 4'd8;

  typedef struct packed {
    logic        write;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [3:0]  size;
  } mem_req_t;

endpackage

// File: rtl/byte_ram.sv
// Byte-addressed storage with eight write lanes and an eight-byte read window.
// Lane k always maps to address base+k; contents are intentionally not reset.
module byte_ram #(
  parameter int DEPTH_BYTES = 1024,
  parameter int AW          = $clog2(DEPTH_BYTES)
) (
  input  logic          clk,
  input  logic [7:0]    we,
  input  logic [AW-1:0] base,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);

  logic [7:0] mem [DEPTH_BYTES];

  always_ff @(posedge clk) begin
    for (int k = 0; k < 8; k++) begin
      if (we[k]) mem[base + AW'(k)] <= wdata[8*k +: 8];
    end
  end

  always_comb begin
    rdata = '0;
    for (int k = 0; k < 8; k++) begin
      rdata[8*k +: 8] = mem[base + AW'(k)];
    end
  end

endmodule

// File: rtl/datamem_responder.sv
// Single-outstanding load/store responder with fixed latency, legality checks
// and a combinational stall back to the pipeline.
//
// state | meaning
// IDLE  | no request in flight, ready to accept
// BUSY  | request latched, latency counter running, not ready
// RESP  | response strobe out, ready to accept the next request
module datamem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [3:0]  req_size,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        stall
);

  localparam int AW  = $clog2(DEPTH_BYTES);
  localparam int AW1 = AW + 1;
  localparam int CW  = $clog2(LATENCY) + 1;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  mem_req_t       req_q, req_d, req_in, cur;
  logic [63:0]    rdata_q, rdata_d;
  logic           err_q, err_d;

  logic           accept, enter_resp;
  logic           size_ok, align_ok, range_ok, legal;
  logic [AW:0]    end_addr;
  logic [7:0]     lane_en, ram_we;
  logic [63:0]    ram_rdata, load_data;

  assign req_ready  = (state_q != BUSY);
  assign accept     = req_valid & req_ready;
  assign stall      = req_valid & ~req_ready;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  assign req_in = '{write: req_write, addr: req_addr, wdata: req_wdata, size: req_size};

  // With single-cycle latency the request is serviced on its own accept edge.
  always_comb begin
    cur = req_q;
    if (LATENCY == 1) cur = req_in;
  end

  always_comb begin
    size_ok  = cur.size inside {XFER_B, XFER_H, XFER_W, XFER_D};
    align_ok = (cur.addr[3:0] & (cur.size - 4'd1)) == 4'd0;
    end_addr = {1'b0, cur.addr[AW-1:0]} + AW1'(cur.size);
    range_ok = (cur.addr[63:AW] == '0) && (end_addr <= AW1'(DEPTH_BYTES));
    legal    = size_ok & align_ok & range_ok;
  end

  always_comb begin
    lane_en   = '0;
    load_data = '0;
    for (int k = 0; k < 8; k++) begin
      lane_en[k]          = (4'(k) < cur.size);
      load_data[8*k +: 8] = lane_en[k] ? ram_rdata[8*k +: 8] : 8'h00;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (accept) begin
          req_d      = req_in;
          cnt_d      = CW'(LATENCY - 1);
          state_d    = (LATENCY == 1) ? RESP : BUSY;
          enter_resp = (LATENCY == 1);
        end
      end
      BUSY: begin
        if (cnt_q == CW'(1)) begin
          state_d    = RESP;
          cnt_d      = '0;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    ram_we  = (enter_resp & legal & cur.write) ? lane_en : 8'h00;
    err_d   = enter_resp & ~legal;
    rdata_d = (enter_resp & legal & ~cur.write) ? load_data : 64'h0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  byte_ram #(
    .DEPTH_BYTES(DEPTH_BYTES),
    .AW         (AW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .base (cur.addr[AW-1:0]),
    .wdata(cur.wdata),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_datamem_responder.sv
// Scoreboard bench: a byte-array reference model predicts each response at
// issue time; an independent monitor pops and compares when resp_valid fires.
module tb_datamem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;
  localparam int LAT3  = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_size = '0;
  logic        req_ready, resp_valid, resp_err, stall;
  logic [63:0] resp_rdata;

  logic        r3_valid = 1'b0, r3_write = 1'b0;
  logic [63:0] r3_addr = '0, r3_wdata = '0;
  logic [3:0]  r3_size = '0;
  logic        r3_ready, r3_resp_valid, r3_resp_err, r3_stall;
  logic [63:0] r3_resp_rdata;

  datamem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .stall(stall)
  );

  datamem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT3)) dut3 (
    .clk(clk), .reset(reset),
    .req_valid(r3_valid), .req_ready(r3_ready), .req_write(r3_write),
    .req_addr(r3_addr), .req_wdata(r3_wdata), .req_size(r3_size),
    .resp_valid(r3_resp_valid), .resp_rdata(r3_resp_rdata), .resp_err(r3_resp_err),
    .stall(r3_stall)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          err;
    logic [63:0] rdata;
    bit          chk;
    int          cyc;
  } exp_t;

  exp_t     sb[$];
  bit [7:0] mm [DEPTH];
  bit       wr [DEPTH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit is_legal(input logic [63:0] a, input logic [3:0] s);
    if (!(s == 4'd1 || s == 4'd2 || s == 4'd4 || s == 4'd8)) return 1'b0;
    if ((a % {60'b0, s}) != 64'd0) return 1'b0;
    if (a > 64'(DEPTH) - {60'b0, s}) return 1'b0;
    return 1'b1;
  endfunction

  // Monitor: every main-DUT output cycle is either a predicted response or quiet.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (resp_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got resp_valid=1 expected none (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          check("resp_cycle", 64'(cyc), 64'(e.cyc));
          check("resp_err", {63'b0, resp_err}, {63'b0, e.err});
          if (e.chk) check("resp_rdata", resp_rdata, e.rdata);
        end
      end else begin
        check("idle_rdata", resp_rdata, 64'h0);
        check("idle_err", {63'b0, resp_err}, 64'h0);
        if (sb.size() > 0 && cyc >= sb[0].cyc) begin
          checks++;
          errors++;
          $display("FAIL missing_resp: got no resp_valid expected one at cycle %0d", sb[0].cyc);
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic issue(input bit w, input logic [63:0] a, input logic [63:0] d,
                       input logic [3:0] s, input bit use_exp,
                       input logic [63:0] exp_rd, input bit exp_err);
    exp_t e;
    bit   ok;
    bit   got;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_size  = s;
    got = 1'b0;
    for (int t = 0; t < 16 && !got; t++) begin
      @(negedge clk);
      got = req_ready;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1 within 16 cycles");
      req_valid = 1'b0;
    end else begin
      ok      = is_legal(a, s);
      e.err   = !ok;
      e.rdata = 64'h0;
      e.chk   = 1'b1;
      e.cyc   = cyc + LAT;
      if (ok && w) begin
        for (int k = 0; k < int'(s); k++) begin
          mm[int'(a[9:0]) + k] = d[8*k +: 8];
          wr[int'(a[9:0]) + k] = 1'b1;
        end
      end else if (ok) begin
        for (int k = 0; k < int'(s); k++) begin
          e.rdata[8*k +: 8] = mm[int'(a[9:0]) + k];
          if (!wr[int'(a[9:0]) + k]) e.chk = 1'b0;
        end
      end
      if (use_exp) begin
        e.err   = exp_err;
        e.rdata = exp_rd;
        e.chk   = 1'b1;
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_write = 1'($urandom_range(0, 1));
      req_addr  = {$urandom, $urandom};
      req_wdata = {$urandom, $urandom};
      req_size  = 4'($urandom);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0]  szt [4];
    logic [63:0] a;
    logic [3:0]  s;
    int          r;
    szt = '{4'd1, 4'd2, 4'd4, 4'd8};

    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_ready", {63'b0, req_ready}, 64'h1);
    check("rst_resp_valid", {63'b0, resp_valid}, 64'h0);
    check("rst_stall", {63'b0, stall}, 64'h0);
    check("rst_rdata", resp_rdata, 64'h0);
    check("rst_err", {63'b0, resp_err}, 64'h0);
    check("rst_ready3", {63'b0, r3_ready}, 64'h1);
    @(posedge clk);
    #1;

    issue(1, 64'h10, 64'h1122334455667788, 4'd8, 1, 64'h0, 1'b0);
    issue(0, 64'h10, 64'h0, 4'd8, 1, 64'h1122334455667788, 1'b0);
    issue(1, 64'h13, 64'h00000000000000AB, 4'd1, 1, 64'h0, 1'b0);
    issue(0, 64'h10, 64'h0, 4'd8, 1, 64'h11223344AB667788, 1'b0);
    issue(0, 64'h13, 64'h0, 4'd1, 1, 64'h00000000000000AB, 1'b0);
    issue(0, 64'h12, 64'h0, 4'd4, 1, 64'h0, 1'b1);
    issue(1, 64'(DEPTH - 8), 64'hCAFEF00D12345678, 4'd8, 1, 64'h0, 1'b0);
    issue(1, 64'(DEPTH - 4), 64'hFFFFFFFFFFFFFFFF, 4'd8, 1, 64'h0, 1'b1);
    issue(0, 64'(DEPTH - 8), 64'h0, 4'd8, 1, 64'hCAFEF00D12345678, 1'b0);
    issue(0, 64'h10, 64'h0, 4'd3, 1, 64'h0, 1'b1);
    issue(0, 64'h10, 64'h0, 4'd0, 1, 64'h0, 1'b1);
    issue(1, 64'hFFFFFFFFFFFFFFF8, 64'h55, 4'd8, 1, 64'h0, 1'b1);
    issue(0, 64'(DEPTH), 64'h0, 4'd1, 1, 64'h0, 1'b1);
    idle_cycles(4);

    // A store interrupted by reset must leave the earlier contents of 0x20 intact.
    issue(1, 64'h20, 64'h0123456789ABCDEF, 4'd8, 1, 64'h0, 1'b0);
    idle_cycles(4);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 64'h20;
    req_wdata = 64'hDEADBEEFFEEDFACE;
    req_size  = 4'd8;
    @(negedge clk);
    check("rstmid_accept_ready", {63'b0, req_ready}, 64'h1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("rstmid_resp_valid", {63'b0, resp_valid}, 64'h0);
    check("rstmid_ready", {63'b0, req_ready}, 64'h1);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rstmid_no_resp", {63'b0, resp_valid}, 64'h0);
    end
    @(posedge clk);
    #1;
    issue(0, 64'h20, 64'h0, 4'd8, 1, 64'h0123456789ABCDEF, 1'b0);

    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      s = szt[$urandom_range(0, 3)];
      if ($urandom_range(0, 7) == 0) s = 4'($urandom);
      if (r < 5)       a = 64'($urandom_range(0, 63)) & ~64'(s - 4'd1);
      else if (r < 7)  a = 64'($urandom_range(0, 63));
      else if (r == 7) a = 64'(DEPTH - 16 + $urandom_range(0, 15));
      else if (r == 8) a = {$urandom, $urandom};
      else             a = 64'(DEPTH + $urandom_range(0, 16));
      issue(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, s, 0, 64'h0, 1'b0);
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
    end
    idle_cycles(5);
    check("sb_drained", 64'(sb.size()), 64'h0);

    // LATENCY=3 instance: valid held high; accepts at 0,3,6, responses at 3,6,9.
    r3_valid = 1'b1;
    r3_write = 1'b1;
    r3_size  = 4'd8;
    r3_addr  = 64'h40;
    r3_wdata = {$urandom, $urandom};
    for (int j = 0; j < 11; j++) begin
      @(negedge clk);
      check("b2b_stall", {63'b0, r3_stall}, {63'b0, (j % 3 != 0) && (j < 9)});
      check("b2b_ready", {63'b0, r3_ready}, {63'b0, !((j % 3 != 0) && (j < 9))});
      check("b2b_resp", {63'b0, r3_resp_valid}, {63'b0, (j == 3) || (j == 6) || (j == 9)});
      if (j == 3 || j == 6 || j == 9) begin
        check("b2b_err", {63'b0, r3_resp_err}, 64'h0);
        check("b2b_rdata", r3_resp_rdata, 64'h0);
      end
      @(posedge clk);
      #1;
      if (j == 0 || j == 3) begin
        r3_addr  = r3_addr + 64'h8;
        r3_wdata = {$urandom, $urandom};
      end
      if (j == 8) r3_valid = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
